// File: rtl/flit_demux_1ton_pkg.sv
// flit_demux_1ton_pkg: shared router FSM encoding and flit control-bit constants
package flit_demux_1ton_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } demux_state_t;

    typedef logic [1:0] flit_ctrl_t;

    localparam int FLIT_HEAD_BIT = 1;
    localparam int FLIT_TAIL_BIT = 0;

endpackage

// File: rtl/flit_demux_1ton_out_reg.sv
// flit_out_reg: one-entry valid/ready output stage that zeroes its data when empty
module flit_out_reg #(
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [P_DATA_WIDTH-1:0] load_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [P_DATA_WIDTH-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (reset || (out_ready && !load)) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end
    end

endmodule

// File: rtl/flit_demux_1ton.sv
// flit_demux_1ton: registered packet-locking 1-to-N flit demultiplexer
module flit_demux_1ton
    import flit_demux_1ton_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_NUM_OUT    = 4,
    parameter int P_SEL_WIDTH  = $clog2(P_NUM_OUT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [P_DATA_WIDTH-1:0]           in_data,
    input  logic [P_SEL_WIDTH-1:0]            in_select,
    input  logic                              in_head,
    input  logic                              in_tail,
    output logic [P_NUM_OUT-1:0]              out_valid,
    input  logic [P_NUM_OUT-1:0]              out_ready,
    output logic [P_NUM_OUT*P_DATA_WIDTH-1:0] out_data,
    output logic                              err_sel,
    output logic                              err_orphan
);

    demux_state_t           state, state_nxt;
    logic [P_SEL_WIDTH-1:0] lock_port, lock_nxt, t;
    logic [P_NUM_OUT-1:0]   load;
    flit_ctrl_t             ctrl;
    logic                   head, tail, sel_legal, has_t, acc;
    logic                   err_sel_nxt, err_orphan_nxt;

    assign ctrl      = {in_head, in_tail};
    assign head      = ctrl[FLIT_HEAD_BIT];
    assign tail      = ctrl[FLIT_TAIL_BIT];
    assign sel_legal = 32'(in_select) < P_NUM_OUT;
    // A head seen in FWD is just another body flit, so the lock decides first
    assign has_t     = (state == FWD) || (state == IDLE && head && sel_legal);
    assign t         = (state == FWD) ? lock_port : in_select;
    assign in_ready  = has_t ? (!out_valid[t] || out_ready[t]) : 1'b1;
    assign acc       = in_valid && in_ready;
    assign load      = (has_t && acc) ? (P_NUM_OUT'(1) << t) : '0;

    always_comb begin
        state_nxt      = state;
        lock_nxt       = lock_port;
        err_sel_nxt    = 1'b0;
        err_orphan_nxt = 1'b0;
        if (acc) begin
            if (state == IDLE) begin
                err_orphan_nxt = !head;
                err_sel_nxt    = head && !sel_legal;
                lock_nxt       = (head && sel_legal) ? in_select : lock_port;
                state_nxt      = (!head || tail) ? IDLE : (sel_legal ? FWD : DROP);
            end else begin
                state_nxt = tail ? IDLE : state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lock_port  <= '0;
            err_sel    <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_port  <= lock_nxt;
            err_sel    <= err_sel_nxt;
            err_orphan <= err_orphan_nxt;
        end
    end

    for (genvar k = 0; k < P_NUM_OUT; k++) begin : g_out
        flit_out_reg #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_out_reg (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*P_DATA_WIDTH +: P_DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_flit_demux_1ton.sv
// tb_flit_demux_1ton: directed-vector bench for the 4-port demux and a 3-port instance for illegal selects
module tb_flit_demux_1ton;

    logic        clk = 1'b0;
    logic        reset, in_valid, use3, in_head, in_tail;
    logic [7:0]  in_data;
    logic [1:0]  in_select;
    logic [3:0]  out_ready;
    logic [2:0]  out_ready3 = 3'b111;
    logic        v4, v3, in_ready, in_ready3, err_sel, err_orphan, err_sel3, err_orphan3;
    logic [3:0]  out_valid;
    logic [2:0]  out_valid3;
    logic [31:0] out_data;
    logic [23:0] out_data3;
    int          n_vec = 0, n_bad = 0;

    assign v4 = in_valid && !use3;
    assign v3 = in_valid && use3;

    always #5 clk = ~clk;

    flit_demux_1ton #(.P_DATA_WIDTH(8), .P_NUM_OUT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(in_ready), .in_data(in_data),
        .in_select(in_select), .in_head(in_head), .in_tail(in_tail), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err_sel(err_sel), .err_orphan(err_orphan)
    );

    flit_demux_1ton #(.P_DATA_WIDTH(8), .P_NUM_OUT(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_ready(in_ready3), .in_data(in_data),
        .in_select(in_select), .in_head(in_head), .in_tail(in_tail), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .err_sel(err_sel3), .err_orphan(err_orphan3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] sel, input logic h, input logic tl, input logic [7:0] d);
        in_valid  = 1'b1;
        in_select = sel;
        in_head   = h;
        in_tail   = tl;
        in_data   = d;
        #1 chk("send_ready", use3 ? in_ready3 : in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; use3 = 1'b0; in_head = 1'b0; in_tail = 1'b0;
        in_data = '0; in_select = '0; out_ready = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", {err_sel, err_orphan}, 0);
        chk("rst_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) begin
            send(2'(i), 1'b1, 1'b1, 8'hA0 + 8'(i));
            chk("single_valid", out_valid, 4'b0001 << i);
            chk("single_data", out_data, 32'(8'hA0 + 8'(i)) << (8 * i));
            chk("single_err", {err_sel, err_orphan}, 0);
        end
        @(negedge clk);
        chk("single_drain", out_valid, 0);

        send(2'd2, 1'b1, 1'b0, 8'h11);
        chk("pkt_f0", {out_valid, out_data}, {4'b0100, 32'h0011_0000});
        send(2'd1, 1'b0, 1'b0, 8'h22);
        chk("pkt_f1", {out_valid, out_data}, {4'b0100, 32'h0022_0000});
        send(2'd3, 1'b1, 1'b0, 8'h33);
        chk("pkt_f2", {out_valid, out_data}, {4'b0100, 32'h0033_0000});
        send(2'd0, 1'b0, 1'b1, 8'h44);
        chk("pkt_f3", {out_valid, out_data}, {4'b0100, 32'h0044_0000});
        chk("pkt_idle", dut.state, 0);
        @(negedge clk);

        out_ready = 4'b1101;
        send(2'd1, 1'b1, 1'b0, 8'h51);
        chk("bp_f0", {out_valid, out_data}, {4'b0010, 32'h0000_5100});
        in_valid = 1'b1; in_head = 1'b0; in_select = 2'd3; in_data = 8'h52;
        #1 chk("bp_ready_low", in_ready, 0);
        @(negedge clk);
        chk("bp_hold1", {out_valid, out_data}, {4'b0010, 32'h0000_5100});
        @(negedge clk);
        chk("bp_hold2", {out_valid, out_data}, {4'b0010, 32'h0000_5100});
        out_ready = 4'hF;
        #1 chk("bp_ready_high", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_f1", {out_valid, out_data}, {4'b0010, 32'h0000_5200});
        send(2'd0, 1'b0, 1'b1, 8'h53);
        chk("bp_f2", {out_valid, out_data}, {4'b0010, 32'h0000_5300});
        @(negedge clk);
        chk("bp_drain", out_valid, 0);

        use3 = 1'b1;
        send(2'd3, 1'b1, 1'b0, 8'h61);
        chk("ill_err", {err_sel3, err_orphan3}, 2'b10);
        chk("ill_valid0", out_valid3, 0);
        send(2'd1, 1'b0, 1'b0, 8'h62);
        chk("ill_err1", err_sel3, 0);
        chk("ill_valid1", {out_valid3, out_data3}, 0);
        send(2'd0, 1'b0, 1'b1, 8'h63);
        chk("ill_valid2", {out_valid3, err_sel3}, 0);
        chk("ill_idle", dut3.state, 0);
        use3 = 1'b0;
        @(negedge clk);

        send(2'd0, 1'b0, 1'b0, 8'h71);
        chk("orph_err", {err_sel, err_orphan}, 2'b01);
        chk("orph_valid", out_valid, 0);
        @(negedge clk);
        chk("orph_pulse", err_orphan, 0);
        send(2'd3, 1'b1, 1'b1, 8'h72);
        chk("orph_next", {out_valid, out_data}, {4'b1000, 32'h7200_0000});
        @(negedge clk);

        send(2'd0, 1'b1, 1'b0, 8'h81);
        send(2'd2, 1'b0, 1'b0, 8'h82);
        chk("rstmid_pre", {out_valid, out_data}, {4'b0001, 32'h0000_0082});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_out", {out_valid, out_data, err_sel, err_orphan}, 0);
        chk("rstmid_state", dut.state, 0);
        send(2'd2, 1'b0, 1'b0, 8'h83);
        chk("rstmid_orph1", {out_valid, err_orphan}, 5'b0000_1);
        send(2'd2, 1'b0, 1'b1, 8'h84);
        chk("rstmid_orph2", {out_valid, err_orphan}, 5'b0000_1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
